led_counter_bank: RTL

- Multi-channel up/down counter bank driving LEDs.
- Each channel's enable, direction and saturate mode are controlled from PS7 EMIO GPIO; the top level handles any GPIO inversion.
- A shared prescaler generates the count tick.
- Adds per-channel load, saturating mode, sticky overflow flags and an atomic snapshot readback for the PS.
- Sits between the PS7 GPIO/EMIO wiring and the board LED pins in the xc7 Zynq examples.

---
 rtl/led_counter_bank.sv | 115 +++++++++++
 1 files changed

// File: rtl/led_counter_bank.sv
// Multi-channel up/down counter bank with shared prescaler, sticky flags, snapshot and LED taps.
// Define GRAY_LED_EN to drive each LED field with the Gray code of its tap field.
module led_counter_bank #(
   parameter int NUM_CH  = 4,
   parameter int CNT_W   = 32,
   parameter int TAP_LSB = 24,
   parameter int LED_W   = 1,
   parameter int PRESC_W = 16,
   localparam int LCH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_CH-1:0]         ch_en,
   input  logic [NUM_CH-1:0]         ch_dir,
   input  logic [NUM_CH-1:0]         ch_sat,
   input  logic [PRESC_W-1:0]        presc_div,
   input  logic                      load_stb,
   input  logic [LCH_W-1:0]          load_ch,
   input  logic [CNT_W-1:0]          load_val,
   input  logic                      flag_clr,
   input  logic                      snap_req,
   output logic                      snap_valid,
   output logic [NUM_CH*CNT_W-1:0]   snap_data,
   output logic [NUM_CH-1:0]         ovf_flag,
   output logic [NUM_CH*LED_W-1:0]   led
);

   localparam logic [PRESC_W-1:0] P_ONE = PRESC_W'(1);
   localparam logic [CNT_W-1:0]   C_ONE = CNT_W'(1);

   logic [PRESC_W-1:0]                presc_cnt_q, presc_cnt_d;
   logic                              tick;
   logic [NUM_CH-1:0][CNT_W-1:0]      cnt_q, cnt_d;
   logic [NUM_CH-1:0]                 ovf_q, ovf_d, ovf_set;
   logic                              snap_valid_q, snap_valid_d;
   logic [NUM_CH-1:0][CNT_W-1:0]      snap_data_q, snap_data_d;
   logic [NUM_CH-1:0][LED_W-1:0]      led_q, led_d;
   logic [LED_W-1:0]                  tap;

   // ">=" makes a lowered divider fire on the next cycle instead of wrapping
   always_comb begin
      tick        = (presc_cnt_q >= presc_div);
      presc_cnt_d = tick ? '0 : presc_cnt_q + P_ONE;
   end

   always_comb begin
      cnt_d   = cnt_q;
      ovf_set = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (load_stb && (int'(load_ch) == i)) begin
            cnt_d[i] = load_val;
         end else if (tick && ch_en[i]) begin
            if (ch_dir[i]) begin
               if (&cnt_q[i]) begin
                  ovf_set[i] = 1'b1;
                  if (!ch_sat[i]) cnt_d[i] = '0;
               end else begin
                  cnt_d[i] = cnt_q[i] + C_ONE;
               end
            end else begin
               if (cnt_q[i] == '0) begin
                  ovf_set[i] = 1'b1;
                  if (!ch_sat[i]) cnt_d[i] = '1;
               end else begin
                  cnt_d[i] = cnt_q[i] - C_ONE;
               end
            end
         end
      end
   end

   // a set event in the same cycle as flag_clr leaves the flag at 1
   always_comb begin
      ovf_d        = (ovf_q & ~{NUM_CH{flag_clr}}) | ovf_set;
      snap_valid_d = snap_req;
      snap_data_d  = snap_req ? cnt_q : snap_data_q;
   end

   always_comb begin
      led_d = '0;
      tap   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         tap = cnt_q[i][TAP_LSB +: LED_W];
`ifdef GRAY_LED_EN
         led_d[i] = tap ^ (tap >> 1);
`else
         led_d[i] = tap;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_cnt_q  <= '0;
         cnt_q        <= '0;
         ovf_q        <= '0;
         snap_valid_q <= 1'b0;
         snap_data_q  <= '0;
         led_q        <= '0;
      end else begin
         presc_cnt_q  <= presc_cnt_d;
         cnt_q        <= cnt_d;
         ovf_q        <= ovf_d;
         snap_valid_q <= snap_valid_d;
         snap_data_q  <= snap_data_d;
         led_q        <= led_d;
      end
   end

   assign snap_valid = snap_valid_q;
   assign snap_data  = snap_data_q;
   assign ovf_flag   = ovf_q;
   assign led        = led_q;

endmodule
